// File: rtl/mips_pkg.sv
// Shared opcode and state encodings for the execute-stage mul/div unit.
// Imported by muldiv_unit and muldiv_datapath.
package mips_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic op_is_md(
    input logic [2:0] op
  );
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (op == OP_DIV)  || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative mul/div datapath: shift-add multiply, restoring divide, sign fix.
// Ports: i_load latches operands, i_step runs one iteration, o_* give the
// sign-corrected HI/LO result and divide-by-zero flag of the last operation.
module muldiv_datapath
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_div,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_srca,
  input  logic [WIDTH-1:0] i_srcb,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_divzero
);

  localparam int W2 = 2 * WIDTH;

  logic [W2-1:0]    r_acc;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_a;
  logic             r_div;
  logic             r_bz;
  logic             r_sq;
  logic             r_sr;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_mul_sum;
  logic [W2-1:0]    w_mul_next;
  logic [WIDTH:0]   w_rem;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [W2-1:0]    w_div_next;
  logic [W2-1:0]    w_prod;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;

  assign w_a_neg = i_signed & i_srca[WIDTH-1];
  assign w_b_neg = i_signed & i_srcb[WIDTH-1];
  // |-2^(W-1)| still fits as an unsigned W-bit magnitude.
  assign w_a_mag = w_a_neg ? -i_srca : i_srca;
  assign w_b_mag = w_b_neg ? -i_srcb : i_srcb;

  // Multiplier sits in the low half and shifts out as the product shifts in.
  assign w_mul_sum = {1'b0, r_acc[W2-1:WIDTH]} +
                     {1'b0, (r_acc[0] ? r_b : '0)};
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Partial remainder is always < divisor, so W+1 bits hold the shifted one
  // and the borrow bit of the trial subtract decides the quotient bit.
  assign w_rem  = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff = w_rem - {1'b0, r_b};
  assign w_ge   = ~w_diff[WIDTH];
  assign w_div_next = {
    (w_ge ? w_diff[WIDTH-1:0] : w_rem[WIDTH-1:0]),
    r_acc[WIDTH-2:0],
    w_ge
  };

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc <= '0;
      r_b   <= '0;
      r_a   <= '0;
      r_div <= 1'b0;
      r_bz  <= 1'b0;
      r_sq  <= 1'b0;
      r_sr  <= 1'b0;
    end else if (i_load) begin
      r_acc <= {{WIDTH{1'b0}}, w_a_mag};
      r_b   <= w_b_mag;
      r_a   <= i_srca;
      r_div <= i_div;
      r_bz  <= (i_srcb == '0);
      r_sq  <= w_a_neg ^ w_b_neg;
      r_sr  <= w_a_neg;
    end else if (i_step) begin
      r_acc <= r_div ? w_div_next : w_mul_next;
    end
  end

  assign w_prod = r_sq ? -r_acc : r_acc;
  assign w_q    = r_acc[WIDTH-1:0];
  assign w_r    = r_acc[W2-1:WIDTH];

  always_comb begin
    o_hi = w_prod[W2-1:WIDTH];
    o_lo = w_prod[WIDTH-1:0];
    if (r_div) begin
      if (r_bz) begin
        o_hi = r_a;
        o_lo = '1;
      end else begin
        o_hi = r_sr ? -w_r : w_r;
        o_lo = r_sq ? -w_q : w_q;
      end
    end
  end

  assign o_divzero = r_div & r_bz;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO writes.
// Ports: start/op/srca/srcb request; busy/done handshake; hi/lo/divzero result.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divzero
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  state_t          r_state;
  logic [CNTW-1:0] r_cnt;

  logic             w_is_md;
  logic             w_is_mthi;
  logic             w_is_mtlo;
  logic             w_is_div;
  logic             w_signed;
  logic             w_load;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;
  logic             w_res_dz;

  assign w_is_md   = op_is_md(op);
  assign w_is_mthi = (op == OP_MTHI);
  assign w_is_mtlo = (op == OP_MTLO);
  assign w_is_div  = (op == OP_DIV) || (op == OP_DIVU);
  assign w_signed  = (op == OP_MULT) || (op == OP_DIV);
  assign w_load    = (r_state == S_IDLE) && start && w_is_md;

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_step   (r_state == S_RUN),
    .i_div    (w_is_div),
    .i_signed (w_signed),
    .i_srca   (srca),
    .i_srcb   (srcb),
    .o_hi     (w_res_hi),
    .o_lo     (w_res_lo),
    .o_divzero(w_res_dz)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divzero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            unique case (1'b1)
              w_is_md: begin
                r_state <= S_RUN;
                r_cnt   <= CNTW'(WIDTH);
                busy    <= 1'b1;
                divzero <= 1'b0;
              end
              w_is_mthi: hi <= srca;
              w_is_mtlo: lo <= srca;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNTW'(1);
          if (r_cnt == CNTW'(1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          hi      <= w_res_hi;
          lo      <= w_res_lo;
          divzero <= w_res_dz;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit with architectural HI/LO registers, parametrised in operand width.
- Successor to the single-cycle combinational ALU. It sits beside the ALU in the execute stage.
- Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and MTHI/MTLO in a single cycle.
- Uses a start/busy/done handshake so the controller can stall dependent MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and ≥ 4.
- CNTW, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- start  in  1  request; sampled only when busy=0
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others = no-op
- srca  in  WIDTH  operand A (dividend / multiplicand / MTHI-MTLO source)
- srcb  in  WIDTH  operand B (divisor / multiplier)
- busy  out  1  unit occupied; new starts are ignored
- done  out  1  one-cycle pulse; HI/LO hold the new result
- hi  out  WIDTH  HI register (product upper half / remainder)
- lo  out  WIDTH  LO register (product lower half / quotient)
- divzero  out  1  sticky until next start: last DIV/DIVU had srcb==0

Behaviour:
- Reset: on any clk edge with reset=0, all of the following are forced:
  - state=IDLE; busy=0, done=0, divzero=0; hi=0, lo=0.
  - Any in-flight operation is aborted and its result discarded.
- FSM states are IDLE, RUN, FIX.
- IDLE, start=1 with op=MULT/MULTU/DIV/DIVU:
  - Latch operands as magnitudes: signed ops take the absolute value; unsigned ops use the operands as-is.
  - Latch result signs. Product sign = a[W-1]^b[W-1]. Quotient sign = a^b. Remainder sign = sign of a.
  - Counter = WIDTH; go to RUN; busy=1 from the next cycle. Clear divzero.
- IDLE, start=1 with MTHI/MTLO:
  - Write srca to hi or lo at that edge; stay IDLE.
  - No busy, no done.
- IDLE, start=1 with an undefined op: no effect.
- RUN: one iteration per cycle; counter decrements; exit to FIX when the counter reaches 0 after the WIDTH-th iteration.
  - Multiply: shift-add on a 2·WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
- FIX:
  - Apply sign correction (two's-complement negate where the sign bit is 1).
  - Write hi/lo; go to IDLE.
  - done=1 in the cycle after the FIX edge; busy is already 0 in that cycle.
- Latency: start is sampled at edge E. hi/lo update and done rise at edge E+WIDTH+1. busy is high for WIDTH+1 cycles.
- start while busy=1: ignored entirely. No queuing, no error flag.
- start in the done cycle: legal; accepted normally.
- Divide by zero (srcb==0), for both DIV and DIVU:
  - Still takes the full latency.
  - Result: hi=srca (original, unmodified), lo=all ones; divzero=1.
- Signed overflow, DIV of −2^(W-1) by −1: lo=−2^(W-1) (0x80000000 at W=32), hi=0. No trap.
- Signed remainder sign always follows the dividend; |hi| < |srcb|.
- hi/lo never change except at FIX, MTHI/MTLO or reset. They hold their values while busy.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package (mips_pkg): op encodings as localparams (OP_MULT…OP_MTLO) and FSM state encodings.
- One natural sub-module: muldiv_datapath (accumulator/shift register, add/subtract, sign fix). muldiv_unit keeps the FSM, counter and handshake.

Test Plan (WIDTH=32):
- MULT srca=0xFFFFFFFF (−1), srcb=0x00000003 → at edge E+33: hi=0xFFFFFFFF, lo=0xFFFFFFFD; done pulses once; busy high 33 cycles. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFD.
- DIV srca=−7 (0xFFFFFFF9), srcb=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU with the same operands → lo=0x7FFFFFFC, hi=0x00000001.
- DIV srca=0x80000000, srcb=0xFFFFFFFF → lo=0x80000000, hi=0, divzero=0. DIVU srca=0x1234, srcb=0 → hi=0x1234, lo=0xFFFFFFFF, divzero=1.
- Start MULT 5×6, then pulse start with DIV 9/3 while busy → second request ignored: hi=0, lo=30; only one done pulse.
- MTHI srca=0xAAAA5555 then MTLO srca=0x0F0F0F0F when idle → hi/lo updated next edge; busy and done stay 0. Start DIVU 100/7 and drive reset=0 for one edge at E+10 → outputs all 0, no done afterward. A subsequent DIVU 100/7 → lo=14, hi=2.
- Back-to-back: new MULTU 0xFFFFFFFF×0xFFFFFFFF starts in the done cycle of the previous op → accepted; hi=0xFFFFFFFE, lo=0x00000001 at the new E+33.
